// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// state encoding and default bus widths.
package mem_arbiter_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/arb_wait_ctr.sv
// Timeout counter for an outstanding memory access. Counts while enabled,
// restarts on clear, and flags the TIMEOUT-th enabled cycle as expired.
// TIMEOUT = 0 disables expiry entirely.
module arb_wait_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Cycle counter: zero in the first waiting cycle, so count == TIMEOUT-1
  // marks the TIMEOUT-th cycle spent waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch
// and load/store. One access is outstanding at a time; loads/stores win
// unless fetch has already been passed over STARVE_MAX times in a row.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          IF_Req,
  input  logic [AW-1:0] IF_Addr,
  output logic [DW-1:0] IF_Data,
  output logic          IF_Valid,
  input  logic          MEM_Rd,
  input  logic          MEM_Wr,
  input  logic [AW-1:0] MEM_Addr,
  input  logic [DW-1:0] MEM_WData,
  output logic [DW-1:0] MEM_RData,
  output logic          MEM_Valid,
  output logic          Stall_IF,
  output logic          Stall_MEM,
  output logic          Mem_Req,
  output logic          Mem_We,
  output logic [AW-1:0] Mem_Addr,
  output logic [DW-1:0] Mem_WData,
  input  logic [DW-1:0] Mem_RData,
  input  logic          Mem_Ack,
  output logic          Err
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          if_elig;
  logic          dm_elig;
  logic          dm_win;
  logic          in_wait;
  logic          expired;

  // A requester still holding its request during its own Valid cycle is not
  // eligible, so a completed access is never issued twice.
  assign if_elig = IF_Req & ~IF_Valid;
  assign dm_elig = (MEM_Rd | MEM_Wr) & ~MEM_Valid;
  assign dm_win  = dm_elig & (~if_elig | (starve_cnt < STARVE_LIM));
  assign in_wait = (state != IDLE);

  assign Stall_IF  = IF_Req & ~IF_Valid;
  assign Stall_MEM = (MEM_Rd | MEM_Wr) & ~MEM_Valid;

  arb_wait_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_ctr (
    .clk     (CLK),
    .rst_n   (RESET),
    .clear   (~in_wait),
    .enable  (in_wait),
    .expired (expired)
  );

  // Arbitration FSM with registered memory-side request and requester results.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      starve_cnt <= '0;
      Mem_Req    <= 1'b0;
      Mem_We     <= 1'b0;
      Mem_Addr   <= '0;
      Mem_WData  <= '0;
      IF_Data    <= '0;
      IF_Valid   <= 1'b0;
      MEM_RData  <= '0;
      MEM_Valid  <= 1'b0;
      Err        <= 1'b0;
    end else begin
      IF_Valid  <= 1'b0;
      MEM_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_win) begin
            state      <= DM_WAIT;
            Mem_Req    <= 1'b1;
            Mem_We     <= MEM_Wr;
            Mem_Addr   <= MEM_Addr;
            Mem_WData  <= MEM_WData;
            starve_cnt <= if_elig ? starve_cnt + 1'b1 : '0;
          end else if (if_elig) begin
            state      <= IF_WAIT;
            Mem_Req    <= 1'b1;
            Mem_We     <= 1'b0;
            Mem_Addr   <= IF_Addr;
            starve_cnt <= '0;
          end
        end
        IF_WAIT, DM_WAIT: begin
          // An ack in the expiry cycle still counts as a normal completion.
          if (Mem_Ack || expired) begin
            state   <= IDLE;
            Mem_Req <= 1'b0;
            Mem_We  <= 1'b0;
            if (!Mem_Ack) begin
              Err <= 1'b1;
            end
            if (state == IF_WAIT) begin
              IF_Valid <= 1'b1;
              IF_Data  <= Mem_Ack ? Mem_RData : '0;
            end else begin
              MEM_Valid <= 1'b1;
              if (!Mem_Ack) begin
                MEM_RData <= '0;
              end else if (!Mem_We) begin
                MEM_RData <= Mem_RData;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IF_Req = 1'b0;
  logic [31:0] IF_Addr = '0;
  logic [31:0] IF_Data;
  logic        IF_Valid;
  logic        MEM_Rd = 1'b0;
  logic        MEM_Wr = 1'b0;
  logic [31:0] MEM_Addr = '0;
  logic [31:0] MEM_WData = '0;
  logic [31:0] MEM_RData;
  logic        MEM_Valid;
  logic        Stall_IF;
  logic        Stall_MEM;
  logic        Mem_Req;
  logic        Mem_We;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [31:0] Mem_RData = '0;
  logic        Mem_Ack = 1'b0;
  logic        Err;

  mem_arbiter #(
    .DW(32), .AW(32), .STARVE_MAX(STARVE), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Data(IF_Data), .IF_Valid(IF_Valid),
    .MEM_Rd(MEM_Rd), .MEM_Wr(MEM_Wr), .MEM_Addr(MEM_Addr), .MEM_WData(MEM_WData),
    .MEM_RData(MEM_RData), .MEM_Valid(MEM_Valid),
    .Stall_IF(Stall_IF), .Stall_MEM(Stall_MEM),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack), .Err(Err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Memory device contents, and the bench's own view of what they should be.
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];

  // Reference model: one outstanding transaction at a time.
  bit          m_busy;
  int          m_k, m_lat, m_starve, m_who;   // m_who: 0 none, 1 fetch, 2 load/store
  logic [31:0] m_addr, m_wdata;
  logic        m_we;
  int          lat_sel;                        // -1 random 1..4, 0 never ack, else fixed
  bit          force_ack;

  // Expected DUT outputs for the current cycle.
  logic        exp_req, exp_if_v, exp_mem_v, exp_err;
  logic [31:0] exp_if_data, exp_mem_rdata;

  bit if_drop, mem_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_starve = 0; m_who = 0; force_ack = 0;
    exp_req = 0; exp_if_v = 0; exp_mem_v = 0; exp_err = 0;
    exp_if_data = '0; exp_mem_rdata = '0;
  endtask

  task automatic check_outputs();
    chk1("mem_req", Mem_Req, exp_req);
    chk1("if_valid", IF_Valid, exp_if_v);
    chk1("mem_valid", MEM_Valid, exp_mem_v);
    chk1("err", Err, exp_err);
    chk("if_data", IF_Data, exp_if_data);
    chk("mem_rdata", MEM_RData, exp_mem_rdata);
    if (exp_req) begin
      chk("mem_addr", Mem_Addr, m_addr);
      chk1("mem_we", Mem_We, m_we);
      if (m_we) chk("mem_wdata", Mem_WData, m_wdata);
    end
  endtask

  // One clock cycle: the model decides this cycle's grant or completion from
  // the current requests, the memory device answers, then outputs are checked
  // just after the next rising edge.
  task automatic cycle();
    logic        nx_req, nx_if_v, nx_mem_v, nx_err;
    logic [31:0] nx_if_data, nx_mem_rdata;
    bit          if_el, dm_el, ack, tmo;
    nx_req = exp_req; nx_if_v = 0; nx_mem_v = 0; nx_err = exp_err;
    nx_if_data = exp_if_data; nx_mem_rdata = exp_mem_rdata;
    Mem_Ack   = force_ack;
    Mem_RData = $urandom;
    if (m_busy) begin
      m_k++;
      ack = (m_lat != 0) && (m_k == m_lat);
      tmo = !ack && (m_k == TMO);
      if (ack) begin
        Mem_Ack   = 1'b1;
        Mem_RData = mem[Mem_Addr[3:0]];
        if (Mem_We) mem[Mem_Addr[3:0]] = Mem_WData;
      end
      if (ack || tmo) begin
        m_busy = 0;
        nx_req = 0;
        if (tmo) nx_err = 1;
        if (m_who == 1) begin
          nx_if_v    = 1;
          nx_if_data = tmo ? 32'h0 : ref_mem[m_addr[3:0]];
          $display("txn fetch addr=%0d data=%h%s", m_addr, nx_if_data, tmo ? " timeout" : "");
        end else begin
          nx_mem_v = 1;
          if (tmo) nx_mem_rdata = 32'h0;
          else if (m_we) ref_mem[m_addr[3:0]] = m_wdata;
          else nx_mem_rdata = ref_mem[m_addr[3:0]];
          $display("txn %s addr=%0d data=%h%s", m_we ? "store" : "load", m_addr,
                   m_we ? m_wdata : nx_mem_rdata, tmo ? " timeout" : "");
        end
      end
    end else begin
      if_el = IF_Req && !exp_if_v;
      dm_el = (MEM_Rd || MEM_Wr) && !exp_mem_v;
      m_who = 0;
      if (dm_el && (!if_el || m_starve < STARVE)) begin
        m_who = 2; m_addr = MEM_Addr; m_we = MEM_Wr; m_wdata = MEM_WData;
        m_starve = if_el ? m_starve + 1 : 0;
      end else if (if_el) begin
        m_who = 1; m_addr = IF_Addr; m_we = 0; m_starve = 0;
      end
      if (m_who != 0) begin
        m_busy = 1; m_k = 0; nx_req = 1;
        m_lat = (lat_sel < 0) ? int'($urandom_range(1, 4)) : lat_sel;
      end
    end
    #1;
    chk1("stall_if", Stall_IF, IF_Req & ~exp_if_v);
    chk1("stall_mem", Stall_MEM, (MEM_Rd | MEM_Wr) & ~exp_mem_v);
    exp_req = nx_req; exp_if_v = nx_if_v; exp_mem_v = nx_mem_v; exp_err = nx_err;
    exp_if_data = nx_if_data; exp_mem_rdata = nx_mem_rdata;
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  // Requesters hold a request through its Valid cycle, then pick anew.
  task automatic rand_reqs(input bit allow_new);
    int op;
    if (IF_Req && exp_if_v) begin
      if_drop = 1;
    end else if (if_drop || !IF_Req) begin
      if_drop = 0;
      IF_Req  = allow_new && ($urandom_range(0, 2) != 0);
      IF_Addr = $urandom_range(0, 15);
    end
    if ((MEM_Rd || MEM_Wr) && exp_mem_v) begin
      mem_drop = 1;
    end else if (mem_drop || !(MEM_Rd || MEM_Wr)) begin
      mem_drop  = 0;
      op        = allow_new ? int'($urandom_range(0, 4)) : 0;
      MEM_Rd    = (op == 2) || (op == 4);
      MEM_Wr    = (op == 3) || (op == 4);
      MEM_Addr  = $urandom_range(0, 15);
      MEM_WData = $urandom;
    end
  endtask

  initial begin
    int          grants [8];
    int          n_g, dm_run;
    logic        prev_req;
    logic [31:0] wdata_t2;

    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    model_reset();
    lat_sel = -1;

    // Reset state.
    #2 RESET = 1'b0;
    #1;
    check_outputs();
    chk1("rst_mem_we", Mem_We, 1'b0);
    chk("rst_mem_addr", Mem_Addr, 32'h0);
    chk("rst_mem_wdata", Mem_WData, 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b1;

    // Fetch from address 5 with latency 3; the request stays high through
    // its Valid cycle and is dropped afterwards without a second issue.
    mem[5] = 32'hA0000005; ref_mem[5] = 32'hA0000005;
    lat_sel = 3;
    IF_Req = 1'b1; IF_Addr = 32'd5;
    for (int c = 1; c <= 7; c++) begin
      cycle();
      chk1($sformatf("t1_req_c%0d", c), Mem_Req, c <= 3);
      chk1($sformatf("t1_ifv_c%0d", c), IF_Valid, c == 4);
      if (c == 4) chk("t1_if_data", IF_Data, 32'hA0000005);
      if (c == 5) IF_Req = 1'b0;
    end

    // Store, latency 1.
    wdata_t2 = 32'h1234;
    lat_sel = 1;
    MEM_Wr = 1'b1; MEM_Addr = 32'd9; MEM_WData = wdata_t2;
    cycle();
    chk1("t2_we", Mem_We, 1'b1);
    chk("t2_addr", Mem_Addr, 32'd9);
    cycle();
    chk1("t2_valid", MEM_Valid, 1'b1);
    chk("t2_rdata_kept", MEM_RData, 32'h0);
    cycle();
    MEM_Wr = 1'b0;
    cycle();
    cycle();

    // Fetch and load both requested continuously, latency 1. The requester
    // that just finished sits out its Valid cycle, so grants alternate.
    IF_Req = 1'b1; IF_Addr = 32'd2;
    MEM_Rd = 1'b1; MEM_Addr = 32'd10;
    n_g = 0; dm_run = 0; prev_req = 1'b0;
    for (int c = 0; c < 13; c++) begin
      cycle();
      if (Mem_Req && !prev_req && n_g < 8) begin
        grants[n_g] = (Mem_Addr == 32'd10) ? 2 : 1;
        dm_run      = (grants[n_g] == 2) ? dm_run + 1 : 0;
        chk1("t3_starve_bound", dm_run <= STARVE, 1'b1);
        n_g++;
      end
      prev_req = Mem_Req;
    end
    chk1("t3_grant_count", n_g >= 6, 1'b1);
    for (int i = 0; i < 6 && i < n_g; i++)
      chk($sformatf("t3_grant%0d", i), grants[i], (i % 2 == 0) ? 2 : 1);
    for (int c = 0; c < 12; c++) begin
      rand_reqs(1'b0);
      cycle();
    end

    // Randomized traffic with random latencies.
    lat_sel = -1;
    for (int c = 0; c < 400; c++) begin
      rand_reqs(1'b1);
      cycle();
    end
    for (int c = 0; c < 16; c++) begin
      rand_reqs(1'b0);
      cycle();
    end

    // Load to address 3 that is never acknowledged.
    lat_sel = 0;
    MEM_Rd = 1'b1; MEM_Wr = 1'b0; MEM_Addr = 32'd3;
    for (int c = 1; c <= 9; c++) begin
      cycle();
      chk1($sformatf("t4_req_c%0d", c), Mem_Req, c <= 8);
    end
    chk1("t4_valid", MEM_Valid, 1'b1);
    chk("t4_rdata", MEM_RData, 32'h0);
    chk1("t4_err", Err, 1'b1);
    cycle();
    MEM_Rd = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    chk1("t4_err_sticky", Err, 1'b1);

    // Reset during a load wait, then a stray ack after release.
    MEM_Rd = 1'b1; MEM_Addr = 32'd4;
    cycle();
    cycle();
    cycle();
    chk1("t5_in_wait", Mem_Req, 1'b1);
    #2 RESET = 1'b0;
    #1;
    model_reset();
    MEM_Rd = 1'b0;
    check_outputs();
    chk1("t5_err_clear", Err, 1'b0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    cycle();
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    chk1("t5_no_valid", MEM_Valid | IF_Valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
